// File: rtl/cpu7_ifu_ibuf_if.sv
// Fetch-to-decode handshake bundle for the instruction buffer.
// master = fetch/decode side, slave = instruction buffer.
interface cpu7_ifu_ibuf_if #(
  parameter int DEPTH = 4,
  parameter int GRLEN = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             fdp_ibuf_vld;
  logic [31:0]      fdp_ibuf_inst;
  logic [GRLEN-1:0] fdp_ibuf_pc;
  logic             fdp_ibuf_exc;
  logic             ibuf_fdp_rdy;
  logic             exu_ifu_stall;
  logic             exu_ifu_flush;
  logic             ifu_exu_vld_d;
  logic [31:0]      ifu_exu_inst_d;
  logic [GRLEN-1:0] ifu_exu_pc_d;
  logic             ifu_exu_exc_d;
  logic [CW-1:0]    ibuf_cnt;

  modport master (
    output fdp_ibuf_vld, fdp_ibuf_inst, fdp_ibuf_pc, fdp_ibuf_exc,
    output exu_ifu_stall, exu_ifu_flush,
    input  ibuf_fdp_rdy, ifu_exu_vld_d, ifu_exu_inst_d, ifu_exu_pc_d,
    input  ifu_exu_exc_d, ibuf_cnt
  );

  modport slave (
    input  fdp_ibuf_vld, fdp_ibuf_inst, fdp_ibuf_pc, fdp_ibuf_exc,
    input  exu_ifu_stall, exu_ifu_flush,
    output ibuf_fdp_rdy, ifu_exu_vld_d, ifu_exu_inst_d, ifu_exu_pc_d,
    output ifu_exu_exc_d, ibuf_cnt
  );
endinterface

// File: rtl/cpu7_ifu_ibuf.sv
// Instruction buffer: circular FIFO of {exc, pc, inst} between I-cache return and decode.
// Optional macro IBUF_BYPASS_EN: an empty buffer forwards the fetch packet to decode in the same cycle.
module cpu7_ifu_ibuf #(
  parameter int DEPTH = 4,
  parameter int GRLEN = 32
) (
  input  logic           clk,
  input  logic           resetn,
  cpu7_ifu_ibuf_if.slave ibuf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic             exc;
    logic [GRLEN-1:0] pc;
    logic [31:0]      inst;
  } entry_t;

  entry_t          mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  logic            empty_s;
  logic            full_s;
  logic            show_in_s;
  logic            byp_s;
  logic            push_s;
  logic            pop_s;
  logic            out_vld_s;
  entry_t          in_s;
  entry_t          head_s;

  // Handshake decode, optional bypass and head selection.
  always_comb begin
    empty_s = (count_r == CW'(0));
    full_s  = (count_r == CW'(DEPTH));
    in_s    = {ibuf.fdp_ibuf_exc, ibuf.fdp_ibuf_pc, ibuf.fdp_ibuf_inst};
`ifdef IBUF_BYPASS_EN
    show_in_s = empty_s & ibuf.fdp_ibuf_vld & ~ibuf.exu_ifu_flush;
    byp_s     = show_in_s & ~ibuf.exu_ifu_stall;
`else
    show_in_s = 1'b0;
    byp_s     = 1'b0;
`endif
    // A bypassed packet is consumed by decode directly and never stored.
    push_s    = ibuf.fdp_ibuf_vld & ~full_s & ~ibuf.exu_ifu_flush & ~byp_s;
    pop_s     = ~empty_s & ~ibuf.exu_ifu_flush & ~ibuf.exu_ifu_stall;
    out_vld_s = (~empty_s | show_in_s) & ~ibuf.exu_ifu_flush;
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else if (show_in_s) begin
      head_s = in_s;
    end else begin
      head_s = '0;
    end
  end

  // Pointer and occupancy state; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (ibuf.exu_ifu_flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_s;
    end
  end

  assign ibuf.ibuf_fdp_rdy   = ~full_s;
  assign ibuf.ifu_exu_vld_d  = out_vld_s;
  assign ibuf.ifu_exu_inst_d = head_s.inst;
  assign ibuf.ifu_exu_pc_d   = head_s.pc;
  assign ibuf.ifu_exu_exc_d  = head_s.exc;
  assign ibuf.ibuf_cnt       = count_r;

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Self-checking bench for cpu7_ifu_ibuf: a queue models buffer contents and predicts every output.
module tb_cpu7_ifu_ibuf;
  localparam int DEPTH = 4;
  localparam int GRLEN = 32;

  typedef struct packed {
    logic        exc;
    logic [31:0] pc;
    logic [31:0] inst;
  } pkt_t;

  logic clk;
  logic resetn;
  int   checks;
  int   passes;
  int   max_cnt;
  pkt_t exp_q[$];
  pkt_t out_q[$];

  cpu7_ifu_ibuf_if #(.DEPTH(DEPTH), .GRLEN(GRLEN)) bif ();

  cpu7_ifu_ibuf #(.DEPTH(DEPTH), .GRLEN(GRLEN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ibuf   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pkt_t mk(input logic e, input logic [31:0] pc, input logic [31:0] inst);
    pkt_t p;
    p.exc  = e;
    p.pc   = pc;
    p.inst = inst;
    return p;
  endfunction

  task automatic drive(input bit v, input pkt_t p, input bit st, input bit fl);
    bif.fdp_ibuf_vld  = v;
    bif.fdp_ibuf_exc  = p.exc;
    bif.fdp_ibuf_pc   = p.pc;
    bif.fdp_ibuf_inst = p.inst;
    bif.exu_ifu_stall = st;
    bif.exu_ifu_flush = fl;
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic do_cycle(output bit acc);
    pkt_t exp_p;
    pkt_t in_p;
    pkt_t got;
    bit   exp_vld;
    bit   byp;
    bit   exp_rdy;
    #3;
    in_p    = mk(bif.fdp_ibuf_exc, bif.fdp_ibuf_pc, bif.fdp_ibuf_inst);
    got     = mk(bif.ifu_exu_exc_d, bif.ifu_exu_pc_d, bif.ifu_exu_inst_d);
    exp_rdy = (exp_q.size() != DEPTH);
    exp_vld = 1'b0;
    exp_p   = '0;
    byp     = 1'b0;
    if (int'(bif.ibuf_cnt) > max_cnt) max_cnt = int'(bif.ibuf_cnt);
    checks++;
    if (bif.ibuf_fdp_rdy !== exp_rdy) $display("FAIL rdy: got %0b expected %0b", bif.ibuf_fdp_rdy, exp_rdy);
    else passes++;
    checks++;
    if (bif.ibuf_cnt !== 3'(exp_q.size())) $display("FAIL cnt: got %0d expected %0d", bif.ibuf_cnt, exp_q.size());
    else passes++;
    if (!bif.exu_ifu_flush) begin
      if (exp_q.size() != 0) begin
        exp_vld = 1'b1;
        exp_p   = exp_q[0];
      end
`ifdef IBUF_BYPASS_EN
      else if (bif.fdp_ibuf_vld) begin
        exp_vld = 1'b1;
        exp_p   = in_p;
        byp     = !bif.exu_ifu_stall;
      end
`endif
    end
    checks++;
    if (bif.ifu_exu_vld_d !== exp_vld) $display("FAIL vld_d: got %0b expected %0b", bif.ifu_exu_vld_d, exp_vld);
    else passes++;
    if (exp_vld || exp_q.size() == 0) begin
      checks++;
      if (got !== exp_p)
        $display("FAIL data_d: got exc=%0b pc=%h inst=%h expected exc=%0b pc=%h inst=%h",
                 got.exc, got.pc, got.inst, exp_p.exc, exp_p.pc, exp_p.inst);
      else passes++;
    end
    acc = bif.fdp_ibuf_vld && exp_rdy && !bif.exu_ifu_flush;
    if (exp_vld && !bif.exu_ifu_stall) begin
      out_q.push_back(exp_p);
      if (!byp) void'(exp_q.pop_front());
    end
    if (bif.exu_ifu_flush) exp_q.delete();
    else if (acc && !byp) exp_q.push_back(in_p);
    @(posedge clk);
    #1;
  endtask

  // Sends a packet list with fetch retry, then drains; stall follows a fixed duty pattern if asked.
  task automatic run_pkts(input pkt_t pk[$], input bit pattern, input int max_cyc);
    int   idx;
    int   cyc;
    bit   acc;
    pkt_t z;
    idx = 0;
    cyc = 0;
    z   = '0;
    while ((idx < pk.size() || exp_q.size() != 0) && cyc < max_cyc) begin
      drive(idx < pk.size(), (idx < pk.size()) ? pk[idx] : z, pattern && (cyc % 3 == 1), 1'b0);
      do_cycle(acc);
      if (acc) idx++;
      cyc++;
    end
    checks++;
    if (idx != pk.size() || exp_q.size() != 0) $display("FAIL drain_timeout: sent %0d of %0d, left %0d", idx, pk.size(), exp_q.size());
    else passes++;
    drive(1'b0, z, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    resetn = 1'b0;
    #3;
    checks++;
    if (bif.ifu_exu_vld_d !== 1'b0 || bif.ibuf_cnt !== 3'd0 || bif.ibuf_fdp_rdy !== 1'b1)
      $display("FAIL reset_ctrl: got vld=%0b cnt=%0d rdy=%0b expected 0/0/1", bif.ifu_exu_vld_d, bif.ibuf_cnt, bif.ibuf_fdp_rdy);
    else passes++;
    checks++;
    if (bif.ifu_exu_inst_d !== 32'd0 || bif.ifu_exu_pc_d !== 32'd0 || bif.ifu_exu_exc_d !== 1'b0)
      $display("FAIL reset_data: got inst=%h pc=%h exc=%0b expected zeros", bif.ifu_exu_inst_d, bif.ifu_exu_pc_d, bif.ifu_exu_exc_d);
    else passes++;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit acc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(1'b0, 32'h1c000100 + 32'(i * 4), 32'h0a000000 + 32'(i)), 1'b1, 1'b0);
      do_cycle(acc);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    resetn = 1'b0;
    #3;
    checks++;
    if (bif.ifu_exu_vld_d !== 1'b0 || bif.ibuf_cnt !== 3'd0 || bif.ibuf_fdp_rdy !== 1'b1)
      $display("FAIL reset_mid: got vld=%0b cnt=%0d rdy=%0b expected 0/0/1", bif.ifu_exu_vld_d, bif.ibuf_cnt, bif.ibuf_fdp_rdy);
    else passes++;
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle(acc);
  endtask

  task automatic test_stream();
    pkt_t pk[$];
    out_q.delete();
    max_cnt = 0;
    for (int i = 0; i < 3; i++) pk.push_back(mk(1'b0, 32'h1c000000 + 32'(i * 4), 32'h02800000 + 32'(i)));
    run_pkts(pk, 1'b0, 20);
    checks++;
    if (max_cnt > 1) $display("FAIL stream_cnt: got max %0d expected at most 1", max_cnt);
    else passes++;
    checks++;
    if (out_q.size() != 3) $display("FAIL stream_len: got %0d expected 3", out_q.size());
    else passes++;
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].pc !== 32'h1c000000 + 32'(i * 4)) $display("FAIL stream_pc: got %h expected %h", out_q[i].pc, 32'h1c000000 + 32'(i * 4));
      else passes++;
    end
  endtask

  task automatic test_full();
    pkt_t pk[$];
    int   idx;
    bit   acc;
    out_q.delete();
    for (int i = 0; i < 5; i++) pk.push_back(mk(1'b0, 32'h1c000200 + 32'(i * 4), 32'h02800401 + 32'(i)));
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(idx < 5, pk[idx], 1'b1, 1'b0);
      do_cycle(acc);
      if (acc) idx++;
    end
    #3;
    checks++;
    if (bif.ibuf_cnt !== 3'd4 || bif.ibuf_fdp_rdy !== 1'b0)
      $display("FAIL full: got cnt=%0d rdy=%0b expected 4/0", bif.ibuf_cnt, bif.ibuf_fdp_rdy);
    else passes++;
    @(posedge clk);
    #1;
    while (idx > 0) begin
      void'(pk.pop_front());
      idx--;
    end
    run_pkts(pk, 1'b0, 30);
    checks++;
    if (out_q.size() != 5) $display("FAIL full_len: got %0d expected 5", out_q.size());
    else passes++;
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].inst !== 32'h02800401 + 32'(i)) $display("FAIL full_order: got %h expected %h", out_q[i].inst, 32'h02800401 + 32'(i));
      else passes++;
    end
  endtask

  task automatic test_flush();
    pkt_t pk[$];
    bit   acc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(1'b0, 32'h1c000300 + 32'(i * 4), 32'h0b000000 + 32'(i)), 1'b1, 1'b0);
      do_cycle(acc);
    end
    out_q.delete();
    drive(1'b1, mk(1'b0, 32'h1c0003f0, 32'h0bad0bad), 1'b0, 1'b1);
    #3;
    checks++;
    if (bif.ifu_exu_vld_d !== 1'b0) $display("FAIL flush_vld: got %0b expected 0", bif.ifu_exu_vld_d);
    else passes++;
    @(posedge clk);
    #1;
    exp_q.delete();
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    checks++;
    if (bif.ibuf_cnt !== 3'd0 || bif.ifu_exu_vld_d !== 1'b0)
      $display("FAIL flush_after: got cnt=%0d vld=%0b expected 0/0", bif.ibuf_cnt, bif.ifu_exu_vld_d);
    else passes++;
    @(posedge clk);
    #1;
    pk.push_back(mk(1'b0, 32'h1c000400, 32'h0c000001));
    run_pkts(pk, 1'b0, 10);
    checks++;
    if (out_q.size() != 1 || out_q[0].pc !== 32'h1c000400)
      $display("FAIL flush_next: got %0d outputs first pc %h expected 1 at 1c000400", out_q.size(), (out_q.size() != 0) ? out_q[0].pc : 32'h0);
    else passes++;
  endtask

  task automatic test_exc();
    pkt_t pk[$];
    out_q.delete();
    pk.push_back(mk(1'b0, 32'h1c00000c, 32'h02800011));
    pk.push_back(mk(1'b1, 32'h1c000010, 32'h02800012));
    pk.push_back(mk(1'b0, 32'h1c000014, 32'h02800013));
    run_pkts(pk, 1'b1, 20);
    checks++;
    if (out_q.size() != 3) $display("FAIL exc_len: got %0d expected 3", out_q.size());
    else passes++;
    for (int i = 0; i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].exc !== (out_q[i].pc == 32'h1c000010)) $display("FAIL exc_tag: pc %h got exc %0b", out_q[i].pc, out_q[i].exc);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    pkt_t pk[$];
    out_q.delete();
    for (int i = 0; i < 10; i++) pk.push_back(mk(i[0], 32'h1c001000 + 32'(i * 4), 32'h03000000 + 32'(i * 7)));
    run_pkts(pk, 1'b1, 100);
    checks++;
    if (out_q.size() != 10) $display("FAIL wrap_len: got %0d expected 10", out_q.size());
    else passes++;
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== pk[i]) $display("FAIL wrap_order: idx %0d got pc %h inst %h expected pc %h inst %h", i, out_q[i].pc, out_q[i].inst, pk[i].pc, pk[i].inst);
      else passes++;
    end
  endtask

  initial begin
    checks  = 0;
    passes  = 0;
    max_cnt = 0;
    test_reset();
    test_reset_mid();
    test_stream();
    test_full();
    test_flush();
    test_exc();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cpu7_ifu_ibuf.md
Name: cpu7_ifu_ibuf

Overview:
Instruction buffer between the I-cache fetch return and the decode stage. It queues fetched {pc, inst, fetch-exception} packets in a small circular FIFO and presents the head entry to decode. Decode uses these outputs directly as the decode-stage instruction and PC, which feed immediate/offset extraction. It absorbs decode stalls without dropping fetches and empties in one cycle on a redirect or flush.

Parameters:
DEPTH, 4, number of buffer entries; must be a power of 2, minimum 2.
GRLEN, 32, PC width.

Ports:
clk  input  1  core clock
resetn  input  1  asynchronous active-low reset
fdp_ibuf_vld  input  1  fetch packet valid
fdp_ibuf_inst  input  32  fetched instruction word
fdp_ibuf_pc  input  GRLEN  PC of fetched instruction
fdp_ibuf_exc  input  1  fetch exception (ADEF/TLB) attached to packet
ibuf_fdp_rdy  output  1  buffer can accept a packet this cycle
exu_ifu_stall  input  1  decode cannot consume this cycle
exu_ifu_flush  input  1  redirect/exception flush; discard all contents
ifu_exu_vld_d  output  1  decode-stage instruction valid
ifu_exu_inst_d  output  32  decode-stage instruction
ifu_exu_pc_d  output  GRLEN  decode-stage PC
ifu_exu_exc_d  output  1  decode-stage fetch exception
ibuf_cnt  output  log2(DEPTH)+1  current occupancy (for perf/debug)

Behaviour:
- Reset (resetn low, async): rd_ptr=0, wr_ptr=0, count=0; ifu_exu_vld_d=0, inst/pc/exc outputs=0, ibuf_fdp_rdy=1. Entry storage need not be reset.
- Storage: DEPTH entries of {exc, pc, inst}; rd_ptr/wr_ptr wrap modulo DEPTH; count in 0..DEPTH.
- ibuf_fdp_rdy = (count != DEPTH). Depends only on registered count, never on same-cycle pop or stall.
- push = fdp_ibuf_vld & ibuf_fdp_rdy & !exu_ifu_flush. Writes the entry at wr_ptr; wr_ptr+1.
- ifu_exu_vld_d = (count != 0) & !exu_ifu_flush. Data outputs = entry at rd_ptr when count!=0, else all-zero.
- pop = ifu_exu_vld_d & !exu_ifu_stall. rd_ptr+1.
- count_next = count + push - pop. Simultaneous push and pop when full is impossible (rdy=0). Simultaneous push and pop at count=1 keeps count=1, and the new entry becomes head next cycle.
- Latency: a packet pushed in cycle N is visible on the outputs in cycle N+1 at the earliest.
- Flush: in the flush cycle, outputs are masked invalid and any push is dropped. Next cycle: count=0, rd_ptr=wr_ptr=0. Flush has priority over push, pop and stall.
- Order: strict FIFO. Entries are never reordered or duplicated. The exc bit travels with its packet.
- Pointer wrap: after DEPTH pushes and pops, pointers return to 0 with no data corruption.
- Assertions for the verification bench: count never exceeds DEPTH, and no push occurs when rdy=0.

Optional Feature:
Macro IBUF_BYPASS_EN.
- Defined: when count==0, fdp_ibuf_vld=1, exu_ifu_flush=0 and exu_ifu_stall=0, the input packet drives ifu_exu_*_d combinationally in the same cycle with vld=1. It is consumed directly and not written, so count stays 0. If empty and stall=1, the packet is written normally and ifu_exu_vld_d=1 shows it combinationally, but pop does not occur.
- Not defined: no combinational path from fdp_* to ifu_exu_*, and minimum latency is 1 cycle.

Test Plan:
- Reset mid-operation: push 3 packets, assert resetn=0 for 1 cycle -> vld_d=0, cnt=0, rdy=1; no stale packet reappears after release.
- Streaming: push pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles with stall=0 -> vld_d high from cycle 1, pc_d sequence 0x1c000000/04/08, cnt never exceeds 1. With IBUF_BYPASS_EN the same sequence appears with 0-cycle latency and cnt=0.
- Full and backpressure: stall=1, push 5 packets (inst 0x02800401..0x02800405) -> rdy drops after the 4th, the 5th is held by fetch, cnt=4. Release stall -> 5 instructions emerge in order, with no duplicates or losses.
- Flush priority: with cnt=3, assert flush together with fdp_ibuf_vld=1 and stall=0 -> vld_d=0 that cycle, no pop, cnt=0 next cycle. A packet pushed the cycle after is the next one output.
- Exception tagging: push a packet with exc=1 at pc 0x1c000010 between two normal packets -> exc_d=1 only while pc_d=0x1c000010.
- Wrap: with DEPTH=4, run 10 push/pop pairs at varying stall duty -> all 10 outputs match the input order, and pointers wrap twice without error.
